// File: rtl/instr_decode_reg.sv
// IF/ID pipeline register: 2-entry skid buffer with MIPS field split.
// Optional stall counter enabled by defining DECODE_STATS_EN.
module instr_decode_reg #(
    parameter int unsigned PC_W    = 32,
    parameter int unsigned INSTR_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr,
    input  logic [PC_W-1:0]    pc_in,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    pc_out,
    output logic [5:0]         opcode,
    output logic [4:0]         rs,
    output logic [4:0]         rt,
    output logic [4:0]         rd,
    output logic [4:0]         shamt,
    output logic [5:0]         funct,
    output logic [15:0]        immediate,
    output logic [25:0]        target,
`ifdef DECODE_STATS_EN
    output logic               imm_zero_sel,
    output logic [31:0]        stall_count
`else
    output logic               imm_zero_sel
`endif
);

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    state_e             state_q, state_d;
    logic [INSTR_W-1:0] main_instr_q, main_instr_d;
    logic [PC_W-1:0]    main_pc_q, main_pc_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               push, pop;

    assign push = in_valid & in_ready_q;
    assign pop  = out_valid_q & out_ready;

    always_comb begin
        state_d      = state_q;
        main_instr_d = main_instr_q;
        main_pc_d    = main_pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (push) begin
                        main_instr_d = instr;
                        main_pc_d    = pc_in;
                        state_d      = StOne;
                    end
                end
                StOne: begin
                    if (push && !pop) begin
                        skid_instr_d = instr;
                        skid_pc_d    = pc_in;
                        state_d      = StTwo;
                    end else if (pop && !push) begin
                        state_d = StEmpty;
                    end else if (pop && push) begin
                        main_instr_d = instr;
                        main_pc_d    = pc_in;
                    end
                end
                StTwo: begin
                    // Skid word always drains to main before anything newer is accepted.
                    if (pop) begin
                        main_instr_d = skid_instr_q;
                        main_pc_d    = skid_pc_q;
                        state_d      = StOne;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
        in_ready_d  = (state_d != StTwo);
        out_valid_d = (state_d != StEmpty);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StEmpty;
            main_instr_q <= '0;
            main_pc_q    <= '0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            main_instr_q <= main_instr_d;
            main_pc_q    <= main_pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign pc_out       = main_pc_q;
    assign opcode       = main_instr_q[31:26];
    assign rs           = main_instr_q[25:21];
    assign rt           = main_instr_q[20:16];
    assign rd           = main_instr_q[15:11];
    assign shamt        = main_instr_q[10:6];
    assign funct        = main_instr_q[5:0];
    assign immediate    = main_instr_q[15:0];
    assign target       = main_instr_q[25:0];
    // ANDI/ORI/XORI zero-extend; LUI and everything else sign-extend.
    assign imm_zero_sel = (main_instr_q[31:26] == 6'h0C) || (main_instr_q[31:26] == 6'h0D) ||
                          (main_instr_q[31:26] == 6'h0E);

`ifdef DECODE_STATS_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else if (in_valid && !in_ready_q && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_instr_decode_reg.sv
// Self-checking bench for instr_decode_reg against a queue-based occupancy model.
module tb_instr_decode_reg;

    logic        clk, reset, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] instr, pc_in, pc_out;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] immediate;
    logic [25:0] target;
    logic        imm_zero_sel;
`ifdef DECODE_STATS_EN
    logic [31:0] stall_count;
`endif

    int checks = 0;
    int passes = 0;

    logic [63:0] mq[$];          // {pc, instr}, front = presented word
    logic [31:0] stall_exp;

    instr_decode_reg #(.PC_W(32), .INSTR_W(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc_in(pc_in), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .pc_out(pc_out), .opcode(opcode), .rs(rs), .rt(rt),
        .rd(rd), .shamt(shamt), .funct(funct), .immediate(immediate), .target(target),
`ifdef DECODE_STATS_EN
        .imm_zero_sel(imm_zero_sel), .stall_count(stall_count)
`else
        .imm_zero_sel(imm_zero_sel)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [114:0] exp_fields(input logic [63:0] e);
        logic [31:0] w;
        logic        z;
        w = e[31:0];
        z = (w[31:26] >= 6'd12) && (w[31:26] <= 6'd14);
        return {e[63:32], w[31:26], w[25:21], w[20:16], w[15:11], w[10:6], w[5:0],
                w[15:0], w[25:0], z};
    endfunction

    function automatic logic [114:0] dut_fields();
        return {pc_out, opcode, rs, rt, rd, shamt, funct, immediate, target, imm_zero_sel};
    endfunction

    // Advance model and DUT by one edge; returns 1 ns after the edge.
    task automatic tick();
        bit rdy, vld;
        @(posedge clk);
        rdy = (mq.size() < 2);
        vld = (mq.size() > 0);
        if (in_valid && !rdy && stall_exp != 32'hFFFF_FFFF) stall_exp++;
        if (flush) begin
            mq.delete();
        end else begin
            if (vld && out_ready) void'(mq.pop_front());
            if (in_valid && rdy) mq.push_back({pc_in, instr});
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mq.delete();
        stall_exp = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        in_valid = 0; flush = 0; out_ready = 0; instr = '0; pc_in = '0;
        do_reset();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL reset_hs: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        else passes++;
        checks++;
        if (dut_fields() !== 115'd0)
            $display("FAIL reset_fields: got %h want 0", dut_fields());
        else passes++;
`ifdef DECODE_STATS_EN
        checks++;
        if (stall_count !== 32'd0)
            $display("FAIL reset_stall: got %0d want 0", stall_count);
        else passes++;
`endif
    endtask

    task automatic test_ori_addi();
        instr = 32'h3402_0F00; pc_in = 32'h0040_0000; in_valid = 1; out_ready = 1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || opcode !== 6'h0D || rt !== 5'd2 || immediate !== 16'h0F00 ||
            imm_zero_sel !== 1'b1 || pc_out !== 32'h0040_0000)
            $display("FAIL ori: v=%b op=%h rt=%0d imm=%h z=%b pc=%h want 1/0d/2/0f00/1/00400000",
                     out_valid, opcode, rt, immediate, imm_zero_sel, pc_out);
        else passes++;
        instr = 32'h2008_FFF9; pc_in = 32'h0040_0004;
        tick();
        checks++;
        if (out_valid !== 1'b1 || immediate !== 16'hFFF9 || imm_zero_sel !== 1'b0 ||
            rs !== 5'd0 || rt !== 5'd8 || pc_out !== 32'h0040_0004)
            $display("FAIL addi: v=%b imm=%h z=%b rs=%0d rt=%0d pc=%h want 1/fff9/0/0/8/00400004",
                     out_valid, immediate, imm_zero_sel, rs, rt, pc_out);
        else passes++;
        instr = 32'h3C01_1234; pc_in = 32'h0040_0008;  // LUI must sign-extend select
        tick();
        in_valid = 0;
        checks++;
        if (imm_zero_sel !== 1'b0 || opcode !== 6'h0F)
            $display("FAIL lui: z=%b op=%h want 0/0f", imm_zero_sel, opcode);
        else passes++;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL drain: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        else passes++;
    endtask

    task automatic test_back_to_back();
        out_ready = 0; in_valid = 1;
        instr = 32'h0022_1820; pc_in = 32'h100;
        tick();
        instr = 32'h3023_00FF; pc_in = 32'h104;
        tick();
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || pc_out !== 32'h100)
            $display("FAIL full: in_ready=%b v=%b pc=%h want 0/1/100", in_ready, out_valid, pc_out);
        else passes++;
        instr = 32'h0800_0040; pc_in = 32'h108;
        tick();
        checks++;
        if (in_ready !== 1'b0 || pc_out !== 32'h100 || dut_fields() !== exp_fields(mq[0]))
            $display("FAIL hold: in_ready=%b pc=%h want 0/100", in_ready, pc_out);
        else passes++;
        in_valid = 0; out_ready = 1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || pc_out !== 32'h104 || in_ready !== 1'b1 ||
            dut_fields() !== exp_fields({32'h104, 32'h3023_00FF}))
            $display("FAIL order2: v=%b pc=%h rdy=%b want 1/104/1", out_valid, pc_out, in_ready);
        else passes++;
        tick();
        checks++;
        if (out_valid !== 1'b0)
            $display("FAIL third_dropped: out_valid=%b pc=%h want 0", out_valid, pc_out);
        else passes++;
    endtask

    task automatic test_flush();
        bit seen;
        out_ready = 0; in_valid = 1;
        instr = 32'h0000_0001; pc_in = 32'h200; tick();
        instr = 32'h0000_0002; pc_in = 32'h204; tick();
        instr = 32'h0000_0003; pc_in = 32'h208; flush = 1;
        tick();
        flush = 0; in_valid = 0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL flush: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        else passes++;
        out_ready = 1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (out_valid) seen = 1;
        end
        checks++;
        if (seen !== 1'b0)
            $display("FAIL flush_gone: flushed word reappeared=%b want 0", seen);
        else passes++;
    endtask

    task automatic test_async_reset();
        out_ready = 0; in_valid = 1;
        instr = 32'h3402_0F00; pc_in = 32'h300; tick();
        instr = 32'h3402_0F01; pc_in = 32'h304; tick();
        in_valid = 0;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || pc_out !== 32'd0)
            $display("FAIL async_reset: v=%b rdy=%b pc=%h want 0/1/0", out_valid, in_ready, pc_out);
        else passes++;
        do_reset();
    endtask

    task automatic test_stats();
`ifdef DECODE_STATS_EN
        do_reset();
        out_ready = 0; in_valid = 1;
        instr = 32'h1111_1111; pc_in = 32'h400; tick();
        instr = 32'h2222_2222; pc_in = 32'h404; tick();
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (stall_count !== 32'd10)
            $display("FAIL stall_count: got %0d want 10", stall_count);
        else passes++;
        flush = 1; tick(); flush = 0; in_valid = 0;
        checks++;
        if (stall_count !== stall_exp)
            $display("FAIL stall_flush: got %0d want %0d", stall_count, stall_exp);
        else passes++;
`endif
    endtask

    task automatic test_random();
        int errs = 0;
        logic [31:0] w;
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            w = $urandom;
            if ($urandom_range(0, 1) == 1) w[31:26] = 6'($urandom_range(11, 15));
            instr = w;
            pc_in = $urandom;
            tick();
            checks++;
            if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 2) ||
                (mq.size() > 0 && dut_fields() !== exp_fields(mq[0]))) begin
                if (errs < 5)
                    $display("FAIL random[%0d]: v=%b rdy=%b fields=%h want v=%b rdy=%b fields=%h",
                             c, out_valid, in_ready, dut_fields(), mq.size() > 0, mq.size() < 2,
                             (mq.size() > 0) ? exp_fields(mq[0]) : 115'd0);
                errs++;
            end else passes++;
        end
        flush = 0; in_valid = 0;
`ifdef DECODE_STATS_EN
        checks++;
        if (stall_count !== stall_exp)
            $display("FAIL random_stall: got %0d want %0d", stall_count, stall_exp);
        else passes++;
`endif
    endtask

    initial begin
        reset = 1'b1; in_valid = 0; flush = 0; out_ready = 0; instr = '0; pc_in = '0;
        stall_exp = '0;
        test_reset();
        test_ori_addi();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_stats();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
